// File: rtl/nes_pad_pkg.sv
// Shared constants and types for the NES controller reader.
package nes_pad_pkg;

   // Button positions in the published vector; matches the pad's serial order.
   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;
   localparam int unsigned NUM_BTNS   = 8;

   // 27 MHz defaults: 12 us latch, 6 us pulse half-period.
   localparam int unsigned DEF_LATCH_CYCLES = 324;
   localparam int unsigned DEF_HALF_CYCLES  = 162;
   localparam int unsigned DEF_CNT_W        = 9;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LATCH = 3'd1,
      ST_LOW   = 3'd2,
      ST_HIGH  = 3'd3,
      ST_DONE  = 3'd4
   } pad_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a selectable reset value.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/nes_gamepad_reader.sv
// One NES pad read per rising poll tick: latch, 8 serial samples, then a
// one-cycle valid strobe with the active-high button vector.
module nes_gamepad_reader
   import nes_pad_pkg::*;
#(
   parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES,
   parameter int unsigned HALF_CYCLES  = DEF_HALF_CYCLES,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_tick,
   input  logic                i_data,
   output logic                o_latch,
   output logic                o_pulse,
   output logic [NUM_BTNS-1:0] o_buttons,
   output logic                o_valid
);

   localparam int unsigned BIT_W = 3;

   pad_state_e          state, state_next;
   logic [CNT_W-1:0]    cnt, cnt_next;
   logic [BIT_W-1:0]    bit_idx, bit_next;
   logic [NUM_BTNS-1:0] shift, shift_next;
   logic [NUM_BTNS-1:0] buttons_next;
   logic                latch_next, pulse_next, valid_next;
   logic                data_sync;
   logic                tick_d;
   logic                start;

   // Idle-high reset keeps a floating/unplugged pad reading as "released".
   sync_2ff #(.RST_VAL(1'b1)) u_data_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .d     (i_data),
      .q     (data_sync)
   );

   // Tracks i_tick even in reset so a tick already high at release is not an edge.
   always_ff @(posedge i_clk) begin
      tick_d <= i_tick;
   end

   assign start = i_tick & ~tick_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         o_latch   <= 1'b0;
         o_pulse   <= 1'b0;
         o_valid   <= 1'b0;
         o_buttons <= '0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         bit_idx   <= bit_next;
         shift     <= shift_next;
         o_latch   <= latch_next;
         o_pulse   <= pulse_next;
         o_valid   <= valid_next;
         o_buttons <= buttons_next;
      end
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt + CNT_W'(1);
      bit_next     = bit_idx;
      shift_next   = shift;
      buttons_next = o_buttons;
      latch_next   = 1'b0;
      pulse_next   = 1'b0;
      valid_next   = 1'b0;

      case (state)
         ST_IDLE: begin
            cnt_next = '0;
            if (start) begin
               state_next = ST_LATCH;
               bit_next   = '0;
               shift_next = '0;
            end
         end
         ST_LATCH: begin
            if (cnt == CNT_W'(LATCH_CYCLES - 1)) begin
               state_next = ST_LOW;
            end
         end
         ST_LOW: begin
            // Sample late in the low phase, long after the pad has shifted.
            if (cnt == CNT_W'(HALF_CYCLES - 1)) begin
               shift_next[bit_idx] = ~data_sync;
               state_next = (bit_idx == BIT_W'(BTN_RIGHT)) ? ST_DONE : ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (cnt == CNT_W'(HALF_CYCLES - 1)) begin
               bit_next   = bit_idx + BIT_W'(1);
               state_next = ST_LOW;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (state_next != state) begin
         cnt_next = '0;
      end

      // Outputs follow the state being entered so they align with it.
      latch_next = (state_next == ST_LATCH);
      pulse_next = (state_next == ST_HIGH);
      valid_next = (state_next == ST_DONE);
      if (valid_next) begin
         buttons_next = shift_next;
      end
   end

endmodule

// File: doc/nes_gamepad_reader.md
Name: nes_gamepad_reader

Overview:
Consumes the 60 Hz poll clock from the 27 MHz clock divider and runs one NES controller read per rising edge of that clock. Each read drives the pad LATCH and PULSE (clock) lines with NES-compliant timing and serially samples the pad DATA line. It then publishes an 8-bit active-high button vector with a one-cycle valid strobe to the input/joypad logic. Sits between the clock divider and the core's controller port model.

Parameters:
LATCH_CYCLES, 324, i_clk cycles LATCH is held high (12 us at 27 MHz)
HALF_CYCLES, 162, i_clk cycles per PULSE high phase and per low/sample phase (6 us at 27 MHz)
CNT_W, 9, width of phase counter; must satisfy 2^CNT_W > LATCH_CYCLES

Ports:
i_clk  in  1  27 MHz system clock
i_rst  in  1  reset, synchronous, active-high
i_tick  in  1  poll clock from divider, i_clk domain (no sync needed); rising edge starts a read
i_data  in  1  pad DATA line, asynchronous, active-low (0 = pressed)
o_latch  out  1  pad LATCH line, active-high
o_pulse  out  1  pad PULSE/clock line, active-high
o_buttons  out  8  [0]=A [1]=B [2]=Select [3]=Start [4]=Up [5]=Down [6]=Left [7]=Right, 1 = pressed
o_valid  out  1  one-cycle strobe; o_buttons updated this cycle

Behaviour:
- i_data passes a 2-FF synchronizer; all sampling uses the synchronized value (2-cycle delay, negligible vs HALF_CYCLES).
- Edge detect: tick_d registers i_tick every cycle, including during reset, so i_tick already high at reset release does NOT start a read. start = i_tick & ~tick_d.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE.
- IDLE: outputs low; on start -> LATCH, counter cleared, bit index = 0. o_latch goes high the cycle after start.
- LATCH: o_latch=1 for exactly LATCH_CYCLES cycles -> LOW.
- LOW: o_latch=0, o_pulse=0 for HALF_CYCLES cycles.
  - On the last LOW cycle, shift[bit] <= ~data_sync.
  - If bit==7 -> DONE; else -> HIGH.
- HIGH: o_pulse=1 for HALF_CYCLES cycles; on exit bit <= bit+1 -> LOW.
- Pulse counts: exactly 7 PULSE high phases per read; 8 samples.
- DONE (1 cycle): o_buttons <= shift, o_valid=1 -> IDLE.
- Timing: o_valid rises 324 + 15*162 = 2754 cycles after o_latch first rises.
- Between o_valid strobes, o_buttons holds its value.
- start while not IDLE (including in DONE) is ignored: no queueing, no restart. A read takes ~102 us, far less than the 16.7 ms poll period.
- Reset, at any point including mid-read:
  - FSM -> IDLE; o_latch, o_pulse, o_valid = 0; o_buttons = 8'h00; shift = 0; counter and bit = 0.
  - Synchronizer flops reset to 1 (released).
  - An interrupted read produces no o_valid.
- Counter: CNT_W bits, counts 0..N-1 per phase, clears on every state change; no wrap beyond the phase length.

Decomposition:
- Package nes_pad_pkg:
  - button index constants BTN_A..BTN_RIGHT (0..7)
  - FSM state enum
  - default LATCH_CYCLES/HALF_CYCLES for 27 MHz
- One sub-module: sync_2ff (generic 2-flop synchronizer, reset value parameter) for i_data.
- FSM, counter and shift register stay in the top.

Test Plan:
- Reset then release with i_tick held 1 -> no o_latch activity for 5000 cycles; o_buttons=8'h00, o_valid=0.
- Tick 0->1 with i_data=1 constant:
  - o_latch high exactly 324 cycles.
  - 7 o_pulse highs of 162 cycles, each separated by 162 low cycles.
  - o_valid 1 cycle at latch_rise+2754.
  - o_buttons=8'h00.
- Pad model drives bit n on DATA per pulse, with A and Start pressed -> o_buttons=8'h09. Repeat with Right only pressed -> 8'h80.
- Extra tick rising edge at latch_rise+1000 -> ignored; single o_valid; the pulse train is unchanged.
- Assert i_rst for 1 cycle at latch_rise+1500 -> o_latch/o_pulse low next cycle, no o_valid, o_buttons=8'h00. The next tick produces a normal full read.
- DATA glitches asynchronously (changes between clock edges) mid-HIGH phase -> sampled values are taken only at LOW-phase ends and match the pad model.
